// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg : shared constants, FSM state type and parity helper for the
//            parametrised UART receiver.                         rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  // Word is zero-extended by the caller; extra zeros do not change the XOR.
  function automatic logic parity_error(input int mode, input logic [8:0] word,
                                        input logic pbit);
    logic x;
    x = (^word) ^ pbit;
    if (mode == PARITY_ODD)       return ~x;
    else if (mode == PARITY_EVEN) return x;
    else                          return 1'b0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync : 2-flop input synchroniser plus 3-sample majority voter
//                around the mid-bit point of the bit counter.     rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx_sync #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            rx,
  input  logic [$clog2(CLKS_PER_BIT)-1:0] cnt,
  output logic                            rx_s,
  output logic                            maj
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int MID = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] SAMPLE_A = CW'(MID - 1);
  localparam logic [CW-1:0] SAMPLE_B = CW'(MID);

  logic meta;
  logic samp_a;
  logic samp_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b1;
      rx_s   <= 1'b1;
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else begin
      meta <= rx;
      rx_s <= meta;
      if (cnt == SAMPLE_A) samp_a <= rx_s;
      if (cnt == SAMPLE_B) samp_b <= rx_s;
    end
  end

  // Third vote is the live sample, so the result is valid at count MID+1.
  assign maj = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);

endmodule

`default_nettype wire

// File: rtl/uart_rx_param.sv
// ---------------------------------------------------------------------------
// uart_rx_param : parametrised UART receiver with false-start rejection,
//                 parity/framing flags and a valid/ready output register. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 valid,
  input  logic                 ready,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int MID = CPB / 2;
  localparam int CW  = $clog2(CPB);
  localparam int BW  = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] TICK     = CW'(MID + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CPB - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err_r;
  logic                 frm_acc;
  logic                 stop_idx;
  logic                 rx_s;
  logic                 maj;
  logic                 tick;
  logic                 last_stop;
  logic                 done;

  uart_rx_sync #(.CLKS_PER_BIT(CPB)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .cnt   (cnt),
    .rx_s  (rx_s),
    .maj   (maj)
  );

  assign tick      = (cnt == TICK);
  assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_idx;
  assign done      = (state == S_STOP) && tick && last_stop;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      par_err_r <= 1'b0;
      frm_acc   <= 1'b0;
      stop_idx  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt       <= '0;
          bit_idx   <= '0;
          stop_idx  <= 1'b0;
          frm_acc   <= 1'b0;
          par_err_r <= 1'b0;
          if (!rx_s) state <= S_START;
        end
        S_WAIT_HIGH: begin
          if (!rx_s)                 cnt <= '0;
          else if (cnt == LAST_CNT)  state <= S_IDLE;
          else                       cnt <= cnt + 1'b1;
        end
        default: begin
          // Counter keeps free-running from the start edge, so every later
          // bit is voted around its own mid-point.
          cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
          if (tick) begin
            case (state)
              S_START: state <= maj ? S_IDLE : S_DATA;
              S_DATA: begin
                shreg   <= {maj, shreg[DATA_BITS-1:1]};
                bit_idx <= bit_idx + 1'b1;
                if (bit_idx == LAST_BIT)
                  state <= (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
              end
              S_PARITY: begin
                par_err_r <= parity_error(PARITY, 9'(shreg), maj);
                state     <= S_STOP;
              end
              S_STOP: begin
                if (!maj) frm_acc <= 1'b1;
                stop_idx <= 1'b1;
                if (last_stop) begin
                  state <= maj ? S_IDLE : S_WAIT_HIGH;
                  cnt   <= '0;
                end
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data       <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      valid      <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!valid || ready) begin
          data       <= shreg;
          parity_err <= par_err_r;
          frame_err  <= frm_acc | ~maj;
          valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_param.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_param : bench for three receiver configurations sharing a clock
//                    (8N1, 8E1, 7O2) at 10 clocks per bit.          rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx_param;

  localparam int CPB = 10;

  typedef struct packed {
    logic [1:0] sel;
    logic       pe;
    logic       fe;
    logic [8:0] d;
  } rec_t;

  typedef struct {
    int         sel;
    logic [8:0] word;
    bit         bad_par;
    logic [1:0] stops;
    int         gap;
    logic       pe;
    logic       fe;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] rx_v = 3'b111;
  logic [2:0] ready_v = 3'b111;
  logic [2:0] valid_v, perr_v, ferr_v, ovr_v, busy_v;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic [2:0][8:0] dat;

  int cfg_bits [3] = '{8, 8, 7};
  int cfg_par  [3] = '{0, 2, 1};
  int cfg_stop [3] = '{1, 1, 2};

  int checks = 0;
  int failures = 0;
  int ovr_cnt [3] = '{0, 0, 0};
  rec_t got [$];
  rec_t exp_q [$];
  vec_t tbl [8];

  always #5 clk = ~clk;

  uart_rx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .rx(rx_v[0]), .data(d0), .parity_err(perr_v[0]), .frame_err(ferr_v[0]),
    .valid(valid_v[0]), .ready(ready_v[0]), .overrun(ovr_v[0]), .busy(busy_v[0]));
  uart_rx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx_v[1]), .data(d1), .parity_err(perr_v[1]), .frame_err(ferr_v[1]),
    .valid(valid_v[1]), .ready(ready_v[1]), .overrun(ovr_v[1]), .busy(busy_v[1]));
  uart_rx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .rx(rx_v[2]), .data(d2), .parity_err(perr_v[2]), .frame_err(ferr_v[2]),
    .valid(valid_v[2]), .ready(ready_v[2]), .overrun(ovr_v[2]), .busy(busy_v[2]));

  assign dat[0] = {1'b0, d0};
  assign dat[1] = {1'b0, d1};
  assign dat[2] = {2'b00, d2};

  // Every accepted handshake and every overrun pulse is logged.
  always @(negedge clk) begin
    rec_t r;
    for (int k = 0; k < 3; k++) begin
      if (rst_n && valid_v[k] && ready_v[k]) begin
        r.sel = 2'(k);
        r.pe  = perr_v[k];
        r.fe  = ferr_v[k];
        r.d   = dat[k];
        got.push_back(r);
      end
      if (ovr_v[k]) ovr_cnt[k]++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, expv);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input int sel, input logic b, input int glitch);
    for (int c = 0; c < CPB; c++) begin
      @(posedge clk);
      #1;
      rx_v[sel] = (glitch != 0 && c == 5) ? ~b : b;
    end
  endtask

  // Frame built straight from the line format: start, LSB-first data,
  // optional parity, stop bits.
  task automatic send_frame(input int sel, input logic [8:0] word, input bit bad_par,
                            input logic [1:0] stops, input int glitch_bit);
    logic q [$];
    logic [8:0] w;
    logic p;
    w = word & 9'((1 << cfg_bits[sel]) - 1);
    q.push_back(1'b0);
    for (int i = 0; i < cfg_bits[sel]; i++) q.push_back(w[i]);
    if (cfg_par[sel] != 0) begin
      p = (cfg_par[sel] == 1) ? ~(^w) : (^w);
      q.push_back(bad_par ? ~p : p);
    end
    for (int s = 0; s < cfg_stop[sel]; s++) q.push_back(stops[s]);
    for (int j = 0; j < q.size(); j++) drive_bit(sel, q[j], (j == glitch_bit) ? 1 : 0);
    rx_v[sel] = 1'b1;
  endtask

  function automatic rec_t model(input int sel, input logic [8:0] word, input bit bad_par,
                                 input logic [1:0] stops);
    rec_t r;
    r.sel = 2'(sel);
    r.d   = word & 9'((1 << cfg_bits[sel]) - 1);
    r.pe  = (cfg_par[sel] != 0) && bad_par;
    r.fe  = (cfg_stop[sel] == 1) ? ~stops[0] : ~(stops[0] & stops[1]);
    return r;
  endfunction

  task automatic compare_queues(input string nm);
    int n;
    clocks(30);
    chk({nm, "_count"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_word%0d", nm, i), 32'(got[i]), 32'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  task automatic random_run(input int sel, input int n);
    logic [8:0] w;
    bit bad;
    logic [1:0] st;
    for (int i = 0; i < n; i++) begin
      w   = 9'($urandom_range(0, (1 << cfg_bits[sel]) - 1));
      bad = (sel != 0) && ($urandom_range(0, 2) == 0);
      st  = (sel == 2 && $urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      exp_q.push_back(model(sel, w, bad, st));
      send_frame(sel, w, bad, st, -1);
      clocks((st[cfg_stop[sel]-1] == 1'b0) ? 25 : $urandom_range(0, 12));
    end
  endtask

  initial begin
    tbl[0] = '{0, 9'h0AB, 1'b0, 2'b11, 0,  1'b0, 1'b0};
    tbl[1] = '{0, 9'h0FF, 1'b0, 2'b11, 0,  1'b0, 1'b0};
    tbl[2] = '{0, 9'h000, 1'b0, 2'b11, 0,  1'b0, 1'b0};
    tbl[3] = '{0, 9'h012, 1'b0, 2'b11, 20, 1'b0, 1'b0};
    tbl[4] = '{1, 9'h0AB, 1'b0, 2'b11, 5,  1'b0, 1'b0};
    tbl[5] = '{1, 9'h012, 1'b1, 2'b11, 20, 1'b1, 1'b0};
    tbl[6] = '{2, 9'h05A, 1'b0, 2'b11, 20, 1'b0, 1'b0};
    tbl[7] = '{2, 9'h02B, 1'b0, 2'b10, 20, 1'b0, 1'b1};

    clocks(3);
    chk("reset_valid", valid_v, 0);
    chk("reset_busy", busy_v, 0);
    chk("reset_data", dat, 0);
    chk("reset_perr", perr_v, 0);
    chk("reset_ferr", ferr_v, 0);
    chk("reset_ovr", ovr_v, 0);
    rst_n = 1'b1;
    clocks(5);

    for (int i = 0; i < 8; i++) begin
      rec_t r;
      r.sel = 2'(tbl[i].sel);
      r.d   = tbl[i].word;
      r.pe  = tbl[i].pe;
      r.fe  = tbl[i].fe;
      exp_q.push_back(r);
      send_frame(tbl[i].sel, tbl[i].word, tbl[i].bad_par, tbl[i].stops, -1);
      clocks(tbl[i].gap);
    end
    compare_queues("table");

    // Stop bit low followed by a held-low line.
    exp_q.push_back(model(0, 9'h055, 1'b0, 2'b00));
    send_frame(0, 9'h055, 1'b0, 2'b00, -1);
    rx_v[0] = 1'b0;
    clocks(30);
    chk("break_busy_low", busy_v[0], 1);
    rx_v[0] = 1'b1;
    clocks(8);
    chk("break_busy_early", busy_v[0], 1);
    clocks(8);
    chk("break_busy_after", busy_v[0], 0);
    exp_q.push_back(model(0, 9'h03C, 1'b0, 2'b11));
    send_frame(0, 9'h03C, 1'b0, 2'b11, -1);
    compare_queues("break");

    // Short idle glitch, then a glitch inside a data bit.
    rx_v[0] = 1'b0;
    clocks(3);
    rx_v[0] = 1'b1;
    clocks(20);
    chk("glitch_busy", busy_v[0], 0);
    compare_queues("false_start");
    exp_q.push_back(model(0, 9'h0A5, 1'b0, 2'b11));
    send_frame(0, 9'h0A5, 1'b0, 2'b11, 3);
    compare_queues("glitch_word");

    chk("ovr_none", ovr_cnt[0] + ovr_cnt[1] + ovr_cnt[2], 0);
    ready_v[0] = 1'b0;
    send_frame(0, 9'h011, 1'b0, 2'b11, -1);
    send_frame(0, 9'h022, 1'b0, 2'b11, -1);
    clocks(5);
    chk("ovr_valid", valid_v[0], 1);
    chk("ovr_data", d0, 8'h11);
    chk("ovr_pulses", ovr_cnt[0], 1);
    exp_q.push_back(model(0, 9'h011, 1'b0, 2'b11));
    ready_v[0] = 1'b1;
    clocks(3);
    chk("drain_valid", valid_v[0], 0);
    chk("drain_data", d0, 8'h11);
    compare_queues("overrun");

    // Reset at data bit 4 on two configurations.
    for (int s = 0; s < 3; s += 2) begin
      drive_bit(s, 1'b0, 0);
      for (int b = 0; b < 4; b++) drive_bit(s, 1'b0, 0);
      rst_n = 1'b0;
      clocks(2);
      chk($sformatf("midrst_busy%0d", s), busy_v[s], 0);
      chk($sformatf("midrst_valid%0d", s), valid_v[s], 0);
      rx_v[s] = 1'b1;
      clocks(1);
      rst_n = 1'b1;
      clocks(20);
      exp_q.push_back(model(s, (s == 0) ? 9'h07E : 9'h05A, 1'b0, 2'b11));
      send_frame(s, (s == 0) ? 9'h07E : 9'h05A, 1'b0, 2'b11, -1);
      compare_queues($sformatf("midrst%0d", s));
    end

    random_run(0, 20);
    random_run(1, 12);
    random_run(2, 12);
    compare_queues("random");
    chk("ovr_final", ovr_cnt[0] + ovr_cnt[1] + ovr_cnt[2], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
